// File: rtl/instr_packer.sv
// instr_packer: packs MIPS R/I/J fields into 32-bit words written to consecutive instruction memory addresses.
// Optional running XOR checksum of written words is built only when PACKER_CHECKSUM_EN is defined.
module instr_packer #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            fmt,
  input  logic [5:0]            opcode,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           immediate_data,
  input  logic [25:0]           address_j,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  full,
  output logic                  err_illegal,
  output logic [31:0]           checksum
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d, word;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  mem_we_q, mem_we_d, err_q, err_d, hs, wr, clr;
  always_comb begin
    hs = state_q == LOAD && in_valid;
    wr = hs && fmt != 2'b11;
    clr = state_q == IDLE && start;
    word = fmt == 2'b00 ? {opcode, rs, rt, rd, shamt, funct} :
           fmt == 2'b01 ? {opcode, rs, rt, immediate_data} : {opcode, address_j};
    state_d = clr ? LOAD : (state_q != IDLE && stop) ? IDLE : (wr && ptr_q == '1) ? FULL : state_q;
    ptr_d = clr ? BASE : wr ? ptr_q + PTR_ONE : ptr_q;
    mem_we_d = wr;
    mem_addr_d = wr ? ptr_q : mem_addr_q;
    mem_wdata_d = wr ? word : mem_wdata_q;
    count_d = clr ? '0 : mem_we_q ? count_q + CNT_ONE : count_q;
    err_d = clr ? 1'b0 : (hs && !wr) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign full = state_q == FULL;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign word_count = count_q;
  assign err_illegal = err_q;
`ifdef PACKER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;
  always_comb checksum_d = clr ? '0 : mem_we_q ? checksum_q ^ mem_wdata_q : checksum_q;
  always_ff @(posedge clk) begin
    if (!reset) checksum_q <= '0;
    else checksum_q <= checksum_d;
  end
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: table vectors, corner sequences and randomized scoreboard for instr_packer.
module tb_instr_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, stop, in_valid, start_s, stop_s, in_valid_s;
  logic [1:0] fmt;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] addr_j;
  logic in_ready, mem_we, full, err_illegal;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [8:0] word_count;
  logic in_ready_s, mem_we_s, full_s, err_s;
  logic [1:0] mem_addr_s;
  logic [31:0] mem_wdata_s, checksum_s;
  logic [2:0] word_count_s;
  int checks = 0, failures = 0;

  instr_packer #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate_data(imm), .address_j(addr_j), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .full(full), .err_illegal(err_illegal),
    .checksum(checksum));

  instr_packer #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .stop(stop_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate_data(imm), .address_j(addr_j), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .word_count(word_count_s), .full(full_s), .err_illegal(err_s),
    .checksum(checksum_s));

  typedef struct {
    logic [1:0] f; logic [5:0] op; logic [4:0] rs, rt, rd, sh; logic [5:0] fn;
    logic [15:0] im; logic [25:0] aj; logic [31:0] w;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    fmt = v.f; opcode = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
    funct = v.fn; imm = v.im; addr_j = v.aj; in_valid = 1'b1;
  endtask

  task automatic pulse_stop_start();
    stop = 1'b1; step(); stop = 1'b0;
    start = 1'b1; step(); start = 1'b0;
  endtask

  function automatic logic [31:0] ref_word(input vec_t v);
    case (v.f)
      2'd0: return 32'(v.op) * 32'h0400_0000 + 32'(v.rs) * 32'h0020_0000 + 32'(v.rt) * 32'h0001_0000
                 + 32'(v.rd) * 32'h800 + 32'(v.sh) * 32'h40 + 32'(v.fn);
      2'd1: return 32'(v.op) * 32'h0400_0000 + 32'(v.rs) * 32'h0020_0000 + 32'(v.rt) * 32'h0001_0000 + 32'(v.im);
      default: return 32'(v.op) * 32'h0400_0000 + 32'(v.aj);
    endcase
  endfunction

  function automatic logic [31:0] ck(input logic [31:0] x);
`ifdef PACKER_CHECKSUM_EN
    return x;
`else
    return x & 32'h0;
`endif
  endfunction

  initial begin
    vec_t r0, v;
    logic [31:0] cs;
    int n_hs, writes;
    logic exp_we, exp_err;
    logic [31:0] exp_data;
    tbl[0] = '{2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h2008_0005};
    tbl[1] = '{2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h010_0000, 32'h0810_0000};
    tbl[2] = '{2'd0, 6'h00, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'h1234, 26'h3ff_ffff, 32'h03ff_ffff};
    tbl[3] = '{2'd1, 6'h23, 5'd29, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hfffc, 26'h3ff_ffff, 32'h8fbf_fffc};
    tbl[4] = '{2'd2, 6'h03, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h3ff_ffff, 32'h0fff_ffff};
    tbl[5] = '{2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hbeef, 26'h2aa_aaaa, 32'h0022_1820};
    r0 = tbl[5];
    reset = 1'b0; start = 1'b1; stop = 1'b0; in_valid = 1'b0;
    start_s = 1'b0; stop_s = 1'b0; in_valid_s = 1'b0;
    fmt = '0; opcode = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; addr_j = '0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_checksum", checksum, 0);
    start = 1'b0; reset = 1'b1; step();
    chk("idle_in_ready", in_ready, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("idle_stop_ignored", in_ready, 0);

    // first R word after start
    start = 1'b1; step(); start = 1'b0;
    chk("load_in_ready", in_ready, 1);
    drive(r0); step(); in_valid = 1'b0;
    chk("r_we", mem_we, 1);
    chk("r_addr", mem_addr, 0);
    chk("r_data", mem_wdata, 32'h0022_1820);
    chk("r_count_before", word_count, 0);
    step();
    chk("r_we_drop", mem_we, 0);
    chk("r_count", word_count, 1);

    // table: back-to-back session starting with the spec I/J pair
    pulse_stop_start();
    chk("restart_count", word_count, 0);
    cs = 0;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]); step();
      chk($sformatf("tbl%0d_we", i), mem_we, 1);
      chk($sformatf("tbl%0d_addr", i), mem_addr, i);
      chk($sformatf("tbl%0d_data", i), mem_wdata, tbl[i].w);
      chk($sformatf("tbl%0d_cksum", i), checksum, ck(cs));
      chk($sformatf("tbl%0d_count", i), word_count, i);
      if (i == 2) chk("ij_cksum", checksum, ck(32'h2818_0005));
      cs ^= tbl[i].w;
    end
    in_valid = 1'b0; step();
    chk("tbl_count", word_count, 6);
    chk("tbl_cksum_final", checksum, ck(cs));

    // illegal tuple between two R tuples
    pulse_stop_start();
    drive(r0); step();
    chk("ill_w0_we", mem_we, 1);
    chk("ill_w0_addr", mem_addr, 0);
    chk("ill_err_clear", err_illegal, 0);
    v = tbl[2]; v.f = 2'b11; drive(v); step();
    chk("ill_no_we", mem_we, 0);
    chk("ill_err_set", err_illegal, 1);
    v = tbl[2]; drive(v); step(); in_valid = 1'b0;
    chk("ill_w1_we", mem_we, 1);
    chk("ill_w1_addr", mem_addr, 1);
    chk("ill_w1_data", mem_wdata, 32'h03ff_ffff);
    step();
    chk("ill_count", word_count, 2);
    chk("ill_err_sticky", err_illegal, 1);
    pulse_stop_start();
    chk("ill_err_start_clear", err_illegal, 0);

    // start while loading is ignored: address keeps counting
    drive(r0); start = 1'b1; step(); start = 1'b0; in_valid = 1'b0;
    chk("start_ign_addr", mem_addr, 0);
    drive(tbl[0]); start = 1'b1; step(); start = 1'b0; in_valid = 1'b0;
    chk("start_ign_addr2", mem_addr, 1);
    step();
    chk("start_ign_count", word_count, 2);

    // handshake coincident with stop is still written
    drive(tbl[1]); stop = 1'b1; step(); stop = 1'b0; in_valid = 1'b0;
    chk("stop_hs_we", mem_we, 1);
    chk("stop_hs_addr", mem_addr, 2);
    chk("stop_hs_data", mem_wdata, 32'h0810_0000);
    chk("stop_idle", in_ready, 0);

    // fill the 4-word instance
    stop_s = 1'b1; step(); stop_s = 1'b0;
    start_s = 1'b1; step(); start_s = 1'b0;
    drive(r0); in_valid = 1'b0; in_valid_s = 1'b1;
    writes = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (mem_we_s) begin
        chk("small_addr", mem_addr_s, writes);
        writes++;
      end
    end
    in_valid_s = 1'b0;
    chk("small_writes", writes, 4);
    chk("small_full", full_s, 1);
    chk("small_in_ready", in_ready_s, 0);
    chk("small_count", word_count_s, 4);
    stop_s = 1'b1; step(); stop_s = 1'b0;
    chk("small_stop_full", full_s, 0);
    chk("small_stop_ready", in_ready_s, 0);

    // reset in the cycle after a handshake
    start = 1'b1; step(); start = 1'b0;
    drive(r0); step(); in_valid = 1'b0;
    chk("rstmid_we_before", mem_we, 1);
    reset = 1'b0; step();
    chk("rstmid_we", mem_we, 0);
    chk("rstmid_count", word_count, 0);
    chk("rstmid_ready", in_ready, 0);
    reset = 1'b1; step();

    // randomized scoreboard
    start = 1'b1; step(); start = 1'b0;
    n_hs = 0; cs = 0; exp_err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      v.f = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      v.op = 6'($urandom); v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom);
      v.sh = 5'($urandom); v.fn = 6'($urandom); v.im = 16'($urandom); v.aj = 26'($urandom);
      drive(v);
      in_valid = ($urandom_range(0, 3) != 0);
      exp_we = in_valid && v.f != 2'd3;
      exp_data = ref_word(v);
      step();
      chk("rnd_count", word_count, n_hs);
      chk("rnd_cksum", checksum, ck(cs));
      if (in_valid && v.f == 2'd3) exp_err = 1'b1;
      chk("rnd_we", mem_we, exp_we);
      chk("rnd_err", err_illegal, exp_err);
      if (exp_we) begin
        chk("rnd_addr", mem_addr, n_hs);
        chk("rnd_data", mem_wdata, exp_data);
        n_hs++;
        cs ^= exp_data;
      end
    end
    in_valid = 1'b0; step();
    chk("rnd_final_count", word_count, n_hs);
    chk("rnd_final_cksum", checksum, ck(cs));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_packer.md
# instr_packer

Sequential encoder that assembles MIPS R/I/J instruction fields into 32-bit instruction words and writes them, one per cycle, into the instruction memory write port at consecutive addresses. It sits between a program-load source (test host or boot loader) and the instruction memory. It is the writer counterpart of the pipeline's field-splitting decode stage. Every word it emits, decoded by that stage, returns the same opcode, rs, rt, rd, shamt, funct, immediate and jump-address fields.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of the instruction memory word address.
- BASE_ADDR, 0, first write address after `start`.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  pulse; begins a load session. Honoured only in IDLE.
- stop  in  1  pulse; ends the session. Honoured in LOAD and FULL.
- in_valid  in  1  field tuple present.
- in_ready  out  1  packer accepts the tuple this cycle.
- fmt  in  2  00=R, 01=I, 10=J, 11=illegal.
- opcode  in  6  bits 31:26 of the word.
- rs, rt, rd  in  5 each  register fields.
- shamt  in  5  shift amount.
- funct  in  6  function field.
- immediate_data  in  16  I-type immediate.
- address_j  in  26  J-type target.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_WIDTH+1  words written this session.
- full  out  1  memory space exhausted.
- err_illegal  out  1  sticky: an fmt=11 tuple was received.
- checksum  out  32  see Configuration.

## Operation
- FSM states: IDLE, LOAD, FULL.
- IDLE:
  - in_ready=0.
  - `start` moves to LOAD, loads the write pointer with BASE_ADDR, and clears word_count, err_illegal and checksum.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid&in_ready) encodes the tuple into the output stage:
    - R: {opcode,rs,rt,rd,shamt,funct}.
    - I: {opcode,rs,rt,immediate_data}.
    - J: {opcode,address_j}.
  - Fields not used by the selected format are ignored.
  - fmt=11: the tuple is consumed, no write occurs, and err_illegal is set until the next `start` or reset.
- Write pointer: increments after each write. word_count increments after each write.
- LOAD→FULL: the handshake that takes the word destined for address 2^ADDR_WIDTH−1. The pointer does not wrap.
- FULL:
  - in_ready=0 and full=1.
  - `stop` returns to IDLE.
- `stop` in LOAD returns to IDLE. A handshake in the same cycle as `stop` is still accepted and written.
- `start` outside IDLE is ignored. `stop` in IDLE is ignored.
- Reset mid-session:
  - A pending write is discarded (mem_we=0 next cycle).
  - All state returns to reset values.

## Timing
- Reset values:
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - word_count=0, full=0, err_illegal=0, checksum=0.
- Latency: a handshake in cycle N gives mem_we=1 for exactly cycle N+1, with mem_addr and mem_wdata valid in that cycle.
- Throughput: one word per cycle. There is no back-pressure from memory.
- in_ready is a registered function of state only; there is no combinational path from in_valid.
- word_count and the pointer update at the edge ending the mem_we cycle.
- full asserts in cycle N+1 of the final handshake.
- err_illegal asserts in cycle N+1 of the illegal handshake.
- With ADDR_WIDTH=8 and BASE_ADDR=0, full asserts after 256 words and word_count=256.

## Configuration
- PACKER_CHECKSUM_EN defined:
  - `checksum` is a running XOR of every word written this session.
  - It updates in the same cycle word_count updates and clears on `start`.
- PACKER_CHECKSUM_EN undefined: `checksum` is tied to 0 and no checksum register exists.

## Test plan
- Reset held low for 3 cycles with start=1 → all outputs at reset values, state IDLE, in_ready=0.
- start; R tuple op=0,rs=1,rt=2,rd=3,shamt=0,funct=0x20 → next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820; then word_count=1.
- Back-to-back I tuple (op=0x08,rs=0,rt=8,imm=5), then J tuple (op=2,addr=0x0100000):
  - Writes 0x20080005 at addr 0, then 0x08100000 at addr 1, on consecutive cycles.
  - With PACKER_CHECKSUM_EN, checksum=0x28180005.
- fmt=11 between two valid R tuples → err_illegal=1 and only 2 writes at addrs 0,1. A subsequent `start` clears err_illegal.
- ADDR_WIDTH=2, BASE_ADDR=0, in_valid held high:
  - 4 writes (addrs 0..3), then full=1 and in_ready=0, with no further writes.
  - `stop` → IDLE.
- Reset asserted in the cycle after a handshake → mem_we=0 in the following cycle, word_count=0.
